instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage directly downstream of the PC register. Consumes the current `pc` and computes `pc_next`, which feeds back into the PC register.
- Issues in-order word requests to instruction memory using a valid/ready handshake.
- Buffers returned instructions, tagged with their PC, for the decoder.
- Handles branch/jump redirects by flushing buffered instructions and dropping responses still in flight.

Parameters:
- XLEN, 32, address and data width.
- DEPTH, 4, capacity shared by in-flight requests and buffered instructions; power of two, ≥ 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pc  in  XLEN  current PC from PC register
- pc_next  out  XLEN  next PC to PC register (combinational)
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  request address (= pc)
- imem_rsp_valid  in  1  response valid; always accepted, in request order, ≥ 1 cycle after accept
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  taken branch/jump from execute
- redirect_pc  in  XLEN  redirect target
- dec_valid  out  1  instruction available
- dec_ready  in  1  decoder accepts
- dec_instr  out  32  instruction
- dec_pc  out  XLEN  PC of dec_instr

Behaviour:
- Reset state:
  - All counters and pointers are 0; drop_cnt = 0.
  - dec_valid = 0 and imem_req_valid = 0 while reset is asserted.
  - dec_instr and dec_pc are 0.
- State:
  - tag FIFO (PCs of accepted, not-yet-returned requests), count `inflight`.
  - instr FIFO ({pc, instr}), count `qcnt`.
  - `drop_cnt` (0..DEPTH).
- Credit:
  - `imem_req_valid` = !reset && !redirect_valid && (inflight + qcnt < DEPTH).
  - Request fires when `imem_req_valid && imem_req_ready`; `imem_req_addr = pc`.
- PC selection:
  - `pc_next` = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : req fire ? pc + 4 : pc.
  - pc + 4 wraps modulo 2^XLEN (0xFFFFFFFC → 0x00000000).
- On request fire: push pc into tag FIFO.
- On imem_rsp_valid:
  - Pop tag FIFO.
  - If drop_cnt > 0: decrement drop_cnt and discard the response.
  - Otherwise: push {tag, imem_rsp_data} into the instr FIFO.
  - A response with an empty tag FIFO is a protocol error; flag it with an assertion; the design ignores it.
- Decode side:
  - dec_valid = qcnt > 0; dec_instr and dec_pc present the FIFO head.
  - Pop when dec_valid && dec_ready.
- Redirect (single cycle):
  - Instr FIFO is cleared; any same-cycle pop and push are suppressed.
  - drop_cnt <= inflight plus 1 if a response for a non-dropped slot arrives this cycle is NOT counted: precisely, drop_cnt_next = inflight_after_this_cycle.
  - Tag FIFO is not cleared; it drains naturally as responses arrive.
  - No request is issued in the redirect cycle, so the target is fetched from the following cycle.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle leave the count unchanged.
  - A response and a redirect in the same cycle: the response is discarded.
- Full: with inflight + qcnt = DEPTH, no request is issued and pc_next = pc, so the PC holds.
- Empty: dec_valid = 0 and dec outputs hold their last values.
- Reset asserted mid-operation: all state clears immediately; responses for pre-reset requests must not arrive after reset (memory is reset too).
- Ordering: FIFO order is preserved; each instruction is paired with its issuing PC.

Decomposition:
- Package `riscv_pkg`:
  - XLEN.
  - ILEN = 32.
  - INSTR_BYTES = 4.
  - `fetch_entry_t` struct {pc, instr}.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/flush/count).
  - Instantiated twice: once as the tag FIFO, once as the instr FIFO (flush used only on the instr FIFO).

Test Plan:
- Streaming: reset, pc starts at 0; memory always ready with 1-cycle latency; dec_ready = 1 -> dec_pc sequence 0x0, 0x4, 0x8, 0xC with matching words; pc_next = pc + 4 every cycle after reset.
- Backpressure: dec_ready = 0 with DEPTH = 4 -> exactly 4 requests fire, then imem_req_valid = 0 and pc_next holds at 0x10; releasing dec_ready drains 0x0–0xC in order.
- Redirect in flight: 2 requests outstanding (0x8, 0xC) and redirect to 0x103 -> pc_next = 0x100; both pending responses are discarded; the next dec_pc is 0x100.
- Redirect coincident with a response: the response is dropped and the FIFO is empty next cycle; no stale instruction is ever presented.
- Memory stall: imem_req_ready = 0 for 3 cycles -> pc stays constant and imem_req_addr is stable; stream resumes without gaps or duplicates.
- Wrap and reset: pc = 0xFFFFFFFC fires -> pc_next = 0x0; async reset pulse mid-stream -> dec_valid drops within the same cycle and counters read 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int ILEN        = 32;
    localparam int INSTR_BYTES = 4;

    // One decoded-side entry: an instruction word tagged with its fetch PC.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a flush that overrides push/pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Overflow/underflow requests are ignored; flush wins over both.
    assign do_push = push && !flush && (count_q != (AW+1)'(DEPTH));
    assign do_pop  = pop  && !flush && (count_q != '0);

    // Next-state pointers and count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues in-order word requests for the current PC, buffers
// returned instructions with their PC, and discards stale work on redirect.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_instr,
    output logic [XLEN-1:0] dec_pc
);

    localparam int CW = $clog2(DEPTH);

    logic [CW:0]       inflight, qcnt;
    logic [CW+1:0]     occupancy;
    logic              req_fire, rsp_take;
    logic              instr_push, instr_pop;
    logic [XLEN-1:0]   tag_pc;
    logic [CW:0]       drop_cnt_q, drop_cnt_d;
    logic [CW:0]       inflight_after;
    fetch_entry_t      push_entry, head_entry;
    fetch_entry_t      last_q, last_d;

    // Requests and buffered words share one pool of DEPTH credits.
    assign occupancy      = {1'b0, inflight} + {1'b0, qcnt};
    assign imem_req_valid = !reset && !redirect_valid && (occupancy < (CW+2)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is ignored rather than popping an empty tag FIFO.
    assign rsp_take       = imem_rsp_valid && (inflight != '0);

    assign instr_push = rsp_take && (drop_cnt_q == '0) && !redirect_valid;
    assign instr_pop  = dec_valid && dec_ready && !redirect_valid;

    assign push_entry.pc    = tag_pc;
    assign push_entry.instr = imem_rsp_data;

    // Next PC: redirect target (word aligned), else advance on an accepted request.
    always_comb begin
        pc_next = pc;
        if (redirect_valid)  pc_next = redirect_pc & ~XLEN'(3);
        else if (req_fire)   pc_next = pc + XLEN'(INSTR_BYTES);
    end

    // Responses still owed for pre-redirect requests get discarded as they return.
    always_comb begin
        inflight_after = inflight + (CW+1)'(req_fire) - (CW+1)'(rsp_take);
        drop_cnt_d     = drop_cnt_q;
        if (redirect_valid)                         drop_cnt_d = inflight_after;
        else if (rsp_take && (drop_cnt_q != '0))    drop_cnt_d = drop_cnt_q - 1'b1;
    end

    // Track the last presented entry so decode outputs hold while empty.
    always_comb begin
        last_d = last_q;
        if (qcnt != '0) last_d = head_entry;
    end

    // Drop counter and held decode entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
            last_q     <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            last_q     <= last_d;
        end
    end

    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_fire),
        .wdata (pc),
        .pop   (rsp_take),
        .flush (1'b0),
        .rdata (tag_pc),
        .count (inflight)
    );

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (instr_push),
        .wdata (push_entry),
        .pop   (instr_pop),
        .flush (redirect_valid),
        .rdata (head_entry),
        .count (qcnt)
    );

    assign dec_valid = (qcnt != '0);
    assign dec_instr = dec_valid ? head_entry.instr : last_q.instr;
    assign dec_pc    = dec_valid ? head_entry.pc    : last_q.pc;

    // Memory must never return a word that was not requested.
    assert property (@(posedge clk) disable iff (reset) !(imem_rsp_valid && (inflight == '0)))
        else $error("instr_fetch: response with no outstanding request");

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; the bench acts as PC register and memory.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    int          checks = 0;
    int          errors = 0;
    int          nfire  = 0;
    logic        rsp_en;
    logic [31:0] mq[$];
    logic [31:0] exp_q[$];

    instr_fetch #(.XLEN(32), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .pc_next        (pc_next),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: present a memory response, score decode handshakes,
    // then update the PC register and memory request queue.
    task automatic cyc();
        logic        fire;
        logic [31:0] addr, nxt;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (rsp_en && mq.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(mq.pop_front());
        end
        #1;
        fire = imem_req_valid && imem_req_ready;
        addr = imem_req_addr;
        nxt  = pc_next;
        if (dec_valid && dec_ready) begin
            if (exp_q.size() > 0) begin
                check("dec_pc", dec_pc, exp_q[0]);
                check("dec_instr", dec_instr, word(exp_q[0]));
                void'(exp_q.pop_front());
            end else begin
                check("dec_unexpected", {31'b0, dec_valid}, 32'd0);
            end
        end
        @(posedge clk);
        #1;
        pc = nxt;
        if (fire) begin
            mq.push_back(addr);
            nfire++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        pc             = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        rsp_en         = 1'b1;
        nfire          = 0;
        mq.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input int n);
        imem_req_ready = 1'b0;
        repeat (n) cyc();
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        pc = 32'h0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b1; rsp_en = 1'b1;
        #2;
        check("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_dec_instr", dec_instr, 32'h0);
        check("rst_dec_pc", dec_pc, 32'h0);

        // Streaming
        do_reset();
        dec_ready = 1'b1; imem_req_ready = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stream_pc_next", pc_next, 32'(i * 4 + 4));
            cyc();
        end
        drain(4);
        check("stream_left", exp_q.size(), 0);
        check("stream_pc", pc, 32'h10);

        // Backpressure
        do_reset();
        dec_ready = 1'b0; imem_req_ready = 1'b1;
        repeat (8) cyc();
        check("bp_fires", nfire, 4);
        #1;
        check("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("bp_pc_next", pc_next, 32'h10);
        dec_ready = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        drain(6);
        check("bp_left", exp_q.size(), 0);

        // Redirect with two requests in flight
        do_reset();
        dec_ready = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h100};
        imem_req_ready = 1'b1; cyc();
        cyc();
        imem_req_ready = 1'b0; cyc();
        imem_req_ready = 1'b1; rsp_en = 1'b0; cyc();
        cyc();
        check("rd_pending", mq.size(), 2);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        #1;
        check("rd_pc_next", pc_next, 32'h100);
        check("rd_req_valid", {31'b0, imem_req_valid}, 32'd0);
        cyc();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0; rsp_en = 1'b1;
        cyc(); cyc();
        #1;
        check("rd_dropped", {31'b0, dec_valid}, 32'd0);
        imem_req_ready = 1'b1; cyc();
        drain(4);
        check("rd_left", exp_q.size(), 0);

        // Redirect coincident with a response
        do_reset();
        dec_ready = 1'b1;
        exp_q = '{32'h40};
        imem_req_ready = 1'b1; cyc();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cyc();
        redirect_valid = 1'b0;
        check("co_pc", pc, 32'h40);
        #1;
        check("co_empty", {31'b0, dec_valid}, 32'd0);
        imem_req_ready = 1'b1; cyc();
        drain(4);
        check("co_left", exp_q.size(), 0);

        // Memory stall
        do_reset();
        dec_ready = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        imem_req_ready = 1'b1; cyc(); cyc();
        for (int i = 0; i < 3; i++) begin
            imem_req_ready = 1'b0;
            #1;
            check("stall_addr", imem_req_addr, 32'h8);
            check("stall_pc_next", pc_next, 32'h8);
            cyc();
        end
        imem_req_ready = 1'b1; cyc(); cyc();
        drain(4);
        check("stall_left", exp_q.size(), 0);
        check("stall_fires", nfire, 4);

        // PC wrap
        do_reset();
        dec_ready = 1'b1;
        pc = 32'hFFFF_FFFC;
        exp_q = '{32'hFFFF_FFFC};
        imem_req_ready = 1'b1;
        #1;
        check("wrap_pc_next", pc_next, 32'h0);
        check("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        cyc();
        drain(3);
        check("wrap_left", exp_q.size(), 0);

        // Asynchronous reset mid-stream
        do_reset();
        dec_ready = 1'b1; imem_req_ready = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h8};
        repeat (3) cyc();
        #1;
        check("ar_pre_valid", {31'b0, dec_valid}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("ar_dec_valid", {31'b0, dec_valid}, 32'd0);
        check("ar_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("ar_dec_pc", dec_pc, 32'h0);
        do_reset();
        dec_ready = 1'b0; imem_req_ready = 1'b1;
        repeat (8) cyc();
        check("ar_fires", nfire, 4);
        dec_ready = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        drain(6);
        check("ar_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
